lsu_ctrl: RTL and testbench

Load/store controller that sits between the CPU execute stage and the data memory (`dmem`), acting as the initiating side of the data-memory interface. It accepts one load or store request at a time over a valid/ready handshake and drives `dmem`'s addr/datain/memop/we. It returns load data or store completion over a valid/ready response channel. Misaligned halfword/word accesses, which `dmem` cannot serve in one access, are split into byte accesses and reassembled here.

---
 rtl/lsu_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller between execute and dmem: one request at a time, split of
// misaligned h/w accesses into byte accesses when LSU_MISALIGN_SPLIT_EN is defined.
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  state;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        legal, misal, req_err;

  always_comb begin
    legal = (req_memop == 3'b000) || (req_memop == 3'b001) || (req_memop == 3'b010) ||
            (req_memop == 3'b100) || (req_memop == 3'b101);
    misal = ((req_memop[1:0] == 2'b01) && req_addr[0]) ||
            ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    req_err = !legal;
`else
    req_err = !legal || misal;
`endif
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_we     = (state == S_ISSUE) && we_q && !rst;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  k, k_nxt, k_last;
  logic [31:0] addr_q, asm_q, asm_ins, ld_ext;
  logic [2:0]  memop_q;
  logic        split_q;

  assign k_nxt  = k + 2'd1;
  assign k_last = (memop_q[1:0] == 2'b10) ? 2'd3 : 2'd1;

  // Current byte merged into the partial word; extension applies only on the last byte.
  always_comb begin
    asm_ins = asm_q;
    asm_ins[{k, 3'b000} +: 8] = mem_dataout[7:0];
    case (memop_q)
      3'b001:  ld_ext = {{16{asm_ins[15]}}, asm_ins[15:0]};
      3'b101:  ld_ext = {16'h0000, asm_ins[15:0]};
      default: ld_ext = asm_ins;
    endcase
  end
`endif

  always_comb begin
    mem_datain = '0;
    if (state == S_ISSUE) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      mem_datain = split_q ? {4{wdata_q[{k, 3'b000} +: 8]}} : wdata_q;
`else
      mem_datain = wdata_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_memop  <= 3'b010;
`ifdef LSU_MISALIGN_SPLIT_EN
      k       <= 2'd0;
      asm_q   <= '0;
      addr_q  <= '0;
      memop_q <= 3'b010;
      split_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          we_q       <= req_we;
          wdata_q    <= req_wdata;
          resp_rdata <= '0;
          resp_err   <= req_err;
`ifdef LSU_MISALIGN_SPLIT_EN
          k       <= 2'd0;
          asm_q   <= '0;
          addr_q  <= req_addr;
          memop_q <= req_memop;
          split_q <= misal;
`endif
          if (req_err) begin
            state <= S_RESP;
          end else begin
            state    <= S_ISSUE;
            mem_addr <= req_addr;
`ifdef LSU_MISALIGN_SPLIT_EN
            mem_memop <= misal ? (req_we ? 3'b000 : 3'b100) : req_memop;
`else
            mem_memop <= req_memop;
`endif
          end
        end
        S_ISSUE: begin
          if (!we_q) begin
            state <= S_WAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (split_q && (k != k_last)) begin
            k        <= k_nxt;
            mem_addr <= addr_q + {30'd0, k_nxt};
`endif
          end else begin
            state <= S_RESP;
          end
        end
        S_WAIT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q && (k != k_last)) begin
            asm_q    <= asm_ins;
            k        <= k_nxt;
            mem_addr <= addr_q + {30'd0, k_nxt};
            state    <= S_ISSUE;
          end else begin
            resp_rdata <= split_q ? ld_ext : mem_dataout;
            state      <= S_RESP;
          end
`else
          resp_rdata <= mem_dataout;
          state      <= S_RESP;
`endif
        end
        default: if (resp_ready) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural byte-addressed dmem (sync read, extending loads).
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, mem_we;
  logic [2:0]  req_memop, mem_memop;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_datain, mem_dataout;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  logic [7:0] mem [0:4095];

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_memop(mem_memop), .mem_we(mem_we), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_mem(input logic [31:0] a, input logic [2:0] op);
    logic [11:0] i;
    logic [31:0] w;
    i = a[11:0];
    w = {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
    case (op)
      3'b000:  rd_mem = {{24{w[7]}}, w[7:0]};
      3'b001:  rd_mem = {{16{w[15]}}, w[15:0]};
      3'b100:  rd_mem = {24'h0, w[7:0]};
      3'b101:  rd_mem = {16'h0, w[15:0]};
      default: rd_mem = w;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [11:0] i;
    i = mem_addr[11:0];
    mem_dataout <= rd_mem(mem_addr, mem_memop);
    if (mem_we) begin
      mem[i] = mem_datain[7:0];
      if (mem_memop == 3'b001 || mem_memop == 3'b010) mem[i + 12'd1] = mem_datain[15:8];
      if (mem_memop == 3'b010) begin
        mem[i + 12'd2] = mem_datain[23:16];
        mem[i + 12'd3] = mem_datain[31:24];
      end
    end
  end

  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; checks latency, data, error, and stability over 'hold' stalled cycles.
  task automatic txn(input string tag, input logic we, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd, input int hold,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_memop = op; req_addr = a; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 40);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rd"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_hold_rd"}, resp_rdata, exp_rd);
      chk({tag, "_hold_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      chk({tag, "_hold_rr"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_memop = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_memop", {29'd0, mem_memop}, 32'd2);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;

    txn("sw_al", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2, 32'h0, 1'b0);
    chk("sw_al_mem", rd_mem(32'h100, 3'b010), 32'hDEADBEEF);
    txn("lw_al", 1'b0, 3'b010, 32'h100, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0);
    txn("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0, 3, 32'hFFFFFFDE, 1'b0);
    txn("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0, 3, 32'h000000DE, 1'b0);
    txn("sh_al", 1'b1, 3'b001, 32'h10, 32'h12348000, 0, 2, 32'h0, 1'b0);
    txn("lh_al", 1'b0, 3'b001, 32'h10, 32'h0, 0, 3, 32'hFFFF8000, 1'b0);
    txn("lhu_al", 1'b0, 3'b101, 32'h10, 32'h0, 0, 3, 32'h00008000, 1'b0);
    txn("sb", 1'b1, 3'b000, 32'h21, 32'hFFFFFF7A, 0, 2, 32'h0, 1'b0);
    chk("sb_mem", rd_mem(32'h20, 3'b010), 32'h00007A00);

    wc = we_cnt;
    txn("op011", 1'b0, 3'b011, 32'h100, 32'h0, 5, 1, 32'h0, 1'b1);
    txn("op111_st", 1'b1, 3'b111, 32'h104, 32'h55555555, 0, 1, 32'h0, 1'b1);
    chk("illegal_no_we", we_cnt, wc);
    chk("illegal_no_write", rd_mem(32'h104, 3'b010), 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
    txn("sw_split", 1'b1, 3'b010, 32'h201, 32'h11223344, 0, 5, 32'h0, 1'b0);
    chk("sw_split_b0", rd_mem(32'h201, 3'b100), 32'h44);
    chk("sw_split_b3", rd_mem(32'h204, 3'b100), 32'h11);
    txn("lw_split", 1'b0, 3'b010, 32'h201, 32'h0, 0, 9, 32'h11223344, 1'b0);
    txn("sh_split", 1'b1, 3'b001, 32'h203, 32'h00008000, 0, 3, 32'h0, 1'b0);
    txn("lh_split", 1'b0, 3'b001, 32'h203, 32'h0, 2, 5, 32'hFFFF8000, 1'b0);
    txn("lhu_split", 1'b0, 3'b101, 32'h203, 32'h0, 0, 5, 32'h00008000, 1'b0);
    txn("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFF, 32'hA1B2C3D4, 0, 5, 32'h0, 1'b0);
    chk("wrap_fff", rd_mem(32'hFFF, 3'b100), 32'hD4);
    chk("wrap_000", rd_mem(32'h0, 3'b101), 32'hB2C3);
    txn("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 0, 9, 32'hA1B2C3D4, 1'b0);

    // Abort a split store during its third ISSUE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010; req_addr = 32'h301; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("abort_idle", {31'd0, req_ready}, 32'd1);
    chk("abort_bytes01", rd_mem(32'h301, 3'b101), 32'h0000F00D);
    chk("abort_bytes23", rd_mem(32'h303, 3'b101), 32'h00000000);
    @(negedge clk) rst = 1'b0;
`else
    wc = we_cnt;
    txn("lw_mis", 1'b0, 3'b010, 32'h202, 32'h0, 0, 1, 32'h0, 1'b1);
    txn("sh_mis", 1'b1, 3'b001, 32'h11, 32'hFFFF, 0, 1, 32'h0, 1'b1);
    txn("sw_mis", 1'b1, 3'b010, 32'h101, 32'h0, 0, 1, 32'h0, 1'b1);
    chk("mis_no_we", we_cnt, wc);
    chk("mis_no_write", rd_mem(32'h100, 3'b010), 32'hDEADBEEF);
    txn("lbu_odd", 1'b0, 3'b100, 32'h101, 32'h0, 0, 3, 32'h000000BE, 1'b0);

    // Abort an aligned store in its ISSUE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010; req_addr = 32'h400; req_wdata = 32'h12345678;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("abort_idle", {31'd0, req_ready}, 32'd1);
    chk("abort_nowrite", rd_mem(32'h400, 3'b010), 32'h0);
    @(negedge clk) rst = 1'b0;
`endif
    wc = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) wc++; end
    chk("abort_no_resp", wc, 0);
    txn("post_abort_lw", 1'b0, 3'b010, 32'h100, 32'h0, 0, 3, 32'hDEADBEEF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
